rsa_exp_sequencer: RTL

Responder side of the RSA enable/clear/end-of-conversion handshake. It consumes en_rsa and clear_rsa from the control FSM and runs left-to-right square-and-multiply modular exponentiation by sequencing an external Montgomery multiplier through a start/done handshake. When the exponentiation completes it raises eoc_rsa back to the control FSM. It sits inside the RSA unit, between the control FSM and the Montgomery multiplier datapath.

---
 rtl/rsa_exp_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rsa_exp_sequencer.sv
// Sequences a Montgomery multiplier through left-to-right square-and-multiply
// exponentiation and answers the control FSM's en/clear/eoc handshake.
//   state   | meaning
//   IDLE    | waiting for en_rsa=1 and clear_rsa=1, exponent latched on exit
//   PRECOMP | M*R2 -> Mbar
//   SQUARE  | P*P for the current exponent bit
//   MULT    | P*Mbar when the current exponent bit is 1
//   FINAL   | P*1, leaves the Montgomery domain
//   DONE    | eoc_rsa held high until an abort
module rsa_exp_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             en_rsa,
    input  logic             clear_rsa,
    input  logic [WIDTH-1:0] exponent,
    output logic             mmm_start,
    output logic [1:0]       mmm_sel,
    input  logic             mmm_done,
    output logic             load_result,
    output logic             busy,
    output logic             eoc_rsa
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECOMP,
        S_SQUARE,
        S_MULT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic [WIDTH-1:0] r_exp, w_exp_nx;
    logic             r_issued, w_issued_nx;
    logic [1:0]       r_sel, w_sel_nx;
    logic             w_abort, w_op, w_complete, w_bit, w_last;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= S_IDLE;
            r_idx    <= IDX_TOP;
            r_exp    <= '0;
            r_issued <= 1'b0;
            r_sel    <= 2'd0;
        end else if (ena) begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_exp    <= w_exp_nx;
            r_issued <= w_issued_nx;
            r_sel    <= w_sel_nx;
        end
    end

    always_comb begin
        w_abort     = !clear_rsa || !en_rsa;
        w_op        = (r_state == S_PRECOMP) || (r_state == S_SQUARE) ||
                      (r_state == S_MULT) || (r_state == S_FINAL);
        w_complete  = w_op && r_issued && mmm_done && !w_abort;
        w_bit       = r_exp[r_idx];
        w_last      = (r_idx == '0);
        mmm_start   = ena && w_op && !r_issued && !w_abort;
        load_result = ena && w_complete;
        busy        = w_op;
        eoc_rsa     = (r_state == S_DONE);
        mmm_sel     = r_sel;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_exp_nx    = r_exp;
        w_issued_nx = r_issued;
        if (w_abort) begin
            w_state_nx  = S_IDLE;
            w_idx_nx    = IDX_TOP;
            w_issued_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_exp_nx   = exponent;
                    w_idx_nx   = IDX_TOP;
                    w_state_nx = S_PRECOMP;
                end
                S_PRECOMP, S_SQUARE, S_MULT, S_FINAL: begin
                    if (!r_issued) begin
                        w_issued_nx = 1'b1;
                    end else if (mmm_done) begin
                        w_issued_nx = 1'b0;
                        case (r_state)
                            S_PRECOMP: w_state_nx = S_SQUARE;
                            S_SQUARE: begin
                                if (w_bit) begin
                                    w_state_nx = S_MULT;
                                end else if (!w_last) begin
                                    w_idx_nx = r_idx - 1'b1;
                                end else begin
                                    w_state_nx = S_FINAL;
                                end
                            end
                            S_MULT: begin
                                if (!w_last) begin
                                    w_state_nx = S_SQUARE;
                                    w_idx_nx   = r_idx - 1'b1;
                                end else begin
                                    w_state_nx = S_FINAL;
                                end
                            end
                            default: w_state_nx = S_DONE;
                        endcase
                    end
                end
                S_DONE:  w_state_nx = S_DONE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Operand select follows the state being entered so it is stable from the start cycle.
    always_comb begin
        case (w_state_nx)
            S_SQUARE: w_sel_nx = 2'd1;
            S_MULT:   w_sel_nx = 2'd2;
            S_FINAL:  w_sel_nx = 2'd3;
            default:  w_sel_nx = 2'd0;
        endcase
    end
endmodule
